// File: rtl/iomem_timer_pwm.sv
// Timer/PWM peripheral on the picosoc iomem bus: free-running counter with
// period/compare, registered PWM pin and level interrupt (WRAP && IRQ_EN).
// Latency: 1 cycle (ready the cycle after select); no stalls, one access per 2 cycles max.
// Ports: clk/reset (async active-high); iomem_valid/wstrb/addr/wdata in;
//        iomem_ready/iomem_rdata out (rdata holds while ready=0); pwm_out; irq.
module iomem_timer_pwm #(
  parameter logic [7:0]  BASE_ADDR = 8'h04,
  parameter int unsigned WIDTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic        pwm_out,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             oneshot_q, oneshot_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             pwm_q, pwm_d;
  logic             irq_q, irq_d;

  logic             sel, wr;
  logic [2:0]       reg_idx;
  logic [31:0]      rd_val;
  logic             wrap_set, wrap_clr;

  // Only the slot byte and the register index participate in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iomem_addr[23:5], iomem_addr[1:0]};

  // Byte-lane merge; lanes beyond WIDTH simply have no bits to update.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                   input logic [31:0]      new_v,
                                                   input logic [3:0]       strb);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (strb[i[4:3]]) r[i] = new_v[i];
    end
    return r;
  endfunction

  // !ready_q blocks a held valid from being accepted twice.
  assign sel     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
  assign wr      = sel && (iomem_wstrb != 4'b0000);
  assign reg_idx = iomem_addr[4:2];

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_CTRL:   rd_val[2:0]       = {oneshot_q, irq_en_q, en_q};
      REG_PERIOD: rd_val[WIDTH-1:0] = period_q;
      REG_CMP:    rd_val[WIDTH-1:0] = cmp_q;
      REG_COUNT:  rd_val[WIDTH-1:0] = count_q;
      REG_STATUS: rd_val[0]         = wrap_q;
      default:    rd_val            = '0;
    endcase
  end

  always_comb begin
    ready_d   = sel;
    rdata_d   = sel ? rd_val : rdata_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = oneshot_q;
    period_d  = period_q;
    cmp_d     = cmp_q;
    count_d   = count_q;
    wrap_set  = 1'b0;
    wrap_clr  = 1'b0;

    if (en_q) begin
      if (count_q >= period_q) begin
        count_d  = '0;
        wrap_set = 1'b1;
        if (oneshot_q) en_d = 1'b0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    // Bus writes come after the counter so a software EN write overrides
    // the one-shot auto-clear in the same cycle.
    if (wr) begin
      case (reg_idx)
        REG_CTRL: begin
          if (iomem_wstrb[0]) begin
            en_d      = iomem_wdata[0];
            irq_en_d  = iomem_wdata[1];
            oneshot_d = iomem_wdata[2];
          end
        end
        REG_PERIOD: period_d = merge_bytes(period_q, iomem_wdata, iomem_wstrb);
        REG_CMP:    cmp_d    = merge_bytes(cmp_q, iomem_wdata, iomem_wstrb);
        REG_STATUS: wrap_clr = iomem_wstrb[0] && iomem_wdata[0];
        default:    ;
      endcase
    end

    // A wrap in the same cycle as the W1C keeps the flag set.
    wrap_d = wrap_set ? 1'b1 : (wrap_clr ? 1'b0 : wrap_q);
    pwm_d  = en_q && (count_q < cmp_q);
    irq_d  = wrap_q && irq_en_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      oneshot_q <= 1'b0;
      period_q  <= '0;
      cmp_q     <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      pwm_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      oneshot_q <= oneshot_d;
      period_q  <= period_d;
      cmp_q     <= cmp_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pwm_out     = pwm_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_timer_pwm.sv
// Bench for iomem_timer_pwm: directed bus traffic, an integer-level reference
// model compared on every falling edge, plus literal expectations per scenario.
// Timing: inputs change 1 unit after the rising edge, outputs sampled on the falling edge.
module tb_iomem_timer_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'b0;
  logic [31:0] iomem_addr = 32'b0;
  logic [31:0] iomem_wdata = 32'b0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        pwm_out;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 0;

  localparam int unsigned MASK = 32'h0000_FFFF;

  iomem_timer_pwm #(.BASE_ADDR(8'h04), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata),
    .pwm_out(pwm_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_ctrl = 0, m_period = 0, m_cmp = 0, m_count = 0, m_rdata = 0;
  bit          m_wrap = 0, m_ready = 0, m_pwm = 0, m_irq = 0;

  function automatic int unsigned merge(int unsigned old_v, int unsigned new_v, logic [3:0] st);
    int unsigned r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (st[b]) r = (r & ~(32'hFF << (8 * b))) | (new_v & (32'hFF << (8 * b)));
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit          sel, wrap_set, en;
    int unsigned idx, nctrl, ncount, rd;
    if (reset) begin
      m_ctrl = 0; m_period = 0; m_cmp = 0; m_count = 0; m_rdata = 0;
      m_wrap = 0; m_ready = 0; m_pwm = 0; m_irq = 0;
    end else begin
      sel = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
      idx = iomem_addr[4:2];
      en  = m_ctrl[0];
      case (idx)
        0: rd = m_ctrl;
        1: rd = m_period;
        2: rd = m_cmp;
        3: rd = m_count;
        4: rd = m_wrap;
        default: rd = 0;
      endcase
      nctrl = m_ctrl; ncount = m_count; wrap_set = 0;
      if (en) begin
        if (m_count >= m_period) begin
          ncount = 0; wrap_set = 1;
          if (m_ctrl[2]) nctrl = m_ctrl & ~32'd1;
        end else begin
          ncount = m_count + 1;
        end
      end
      m_pwm = en && (m_count < m_cmp);
      m_irq = m_wrap && m_ctrl[1];
      if (sel) m_rdata = rd;
      if (sel && iomem_wstrb != 4'b0) begin
        case (idx)
          0: if (iomem_wstrb[0]) nctrl = iomem_wdata & 32'd7;
          1: m_period = merge(m_period, iomem_wdata, iomem_wstrb) & MASK;
          2: m_cmp    = merge(m_cmp, iomem_wdata, iomem_wstrb) & MASK;
          4: if (iomem_wstrb[0] && iomem_wdata[0]) m_wrap = 0;
          default: ;
        endcase
      end
      if (wrap_set) m_wrap = 1;
      m_ctrl = nctrl; m_count = ncount; m_ready = sel;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
      check("rdata", iomem_rdata, m_rdata);
      check("pwm",   {31'b0, pwm_out}, {31'b0, m_pwm});
      check("irq",   {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output bit ok);
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    ok = 0; rd = '0;
    for (int n = 0; n < 4 && !ok; n++) begin
      @(negedge clk);
      if (iomem_ready) begin ok = 1; rd = iomem_rdata; end
    end
    @(posedge clk); #1;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; bit ok;
    bus_access(a, d, s, rd, ok);
    check("wr_ack", {31'b0, ok}, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; bit ok;
    bus_access(a, 32'h0, 4'b0, rd, ok);
    check({name, "_ack"}, {31'b0, ok}, 32'd1);
    check(name, rd, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int hi; bit got;
    #1 reset = 1'b1;
    #1 checking = 1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_pwm",   {31'b0, pwm_out}, 32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    reset = 1'b0;

    // Reset values of every register, plus an unmapped slot.
    for (int r = 0; r < 5; r++) rd_chk("rst_reg", 32'h0400_0000 + 32'(4 * r), 32'd0);
    rd_chk("unmapped", 32'h0400_0018, 32'd0);

    // PERIOD=4, CMP=2, EN: pwm high 2 of every 5 cycles.
    wr(32'h0400_0004, 32'd4, 4'hF);
    wr(32'h0400_0008, 32'd2, 4'hF);
    wr(32'h0400_0000, 32'd1, 4'hF);
    repeat (3) @(posedge clk);
    hi = 0;
    repeat (20) begin @(negedge clk); hi += int'(pwm_out); end
    check("pwm_duty", 32'(hi), 32'd8);
    rd_chk("wrap_set", 32'h0400_0010, 32'd1);
    rd_chk("ctrl_en",  32'h0400_0000, 32'd1);
    wr(32'h0400_0000, 32'd0, 4'hF);
    wr(32'h0400_0010, 32'd1, 4'hF);
    rd_chk("wrap_clr", 32'h0400_0010, 32'd0);

    // Interrupt with PERIOD=9.
    wr(32'h0400_0004, 32'd9, 4'hF);
    wr(32'h0400_0000, 32'd3, 4'hF);
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin @(negedge clk); got = irq; end
    check("irq_rise", {31'b0, got}, 32'd1);
    wr(32'h0400_0010, 32'd1, 4'hF);
    @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'd0);
    rd_chk("wrap_after_w1c", 32'h0400_0010, 32'd0);

    // PERIOD=0 wraps every enabled cycle, so W1C always collides with a set.
    wr(32'h0400_0000, 32'd1, 4'hF);
    wr(32'h0400_0004, 32'd0, 4'hF);
    wr(32'h0400_0010, 32'd1, 4'hF);
    rd_chk("w1c_collide", 32'h0400_0010, 32'd1);
    rd_chk("count_p0",    32'h0400_000C, 32'd0);
    wr(32'h0400_0000, 32'd0, 4'hF);
    wr(32'h0400_0010, 32'd1, 4'hF);
    rd_chk("wrap_clr2",   32'h0400_0010, 32'd0);

    // One-shot with PERIOD=3.
    wr(32'h0400_0004, 32'd3, 4'hF);
    wr(32'h0400_0000, 32'd5, 4'hF);
    repeat (12) @(posedge clk);
    rd_chk("oneshot_ctrl",  32'h0400_0000, 32'd4);
    rd_chk("oneshot_count", 32'h0400_000C, 32'd0);
    rd_chk("oneshot_wrap",  32'h0400_0010, 32'd1);
    repeat (6) @(posedge clk);
    rd_chk("oneshot_hold",  32'h0400_000C, 32'd0);

    // Byte strobes, width truncation, ignored address bits, ro/unmapped writes.
    wr(32'h0400_0004, 32'h0000_1234, 4'hF);
    wr(32'h0400_0004, 32'hFFFF_FFFF, 4'b0001);
    rd_chk("period_strb", 32'h0400_0004, 32'h0000_12FF);
    rd_chk("addr_alias",  32'h04AB_CDE7, 32'h0000_12FF);
    wr(32'h0400_0008, 32'hFFFF_FFFF, 4'hF);
    rd_chk("cmp_trunc",   32'h0400_0008, 32'h0000_FFFF);
    wr(32'h0400_000C, 32'h0000_0055, 4'hF);
    rd_chk("count_ro",    32'h0400_000C, 32'd0);
    wr(32'h0400_001C, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_w",  32'h0400_001C, 32'd0);

    // Other slot: never acknowledged.
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0500_0000; iomem_wstrb = 4'b0;
    hi = 0;
    repeat (5) begin @(negedge clk); hi += int'(iomem_ready); end
    check("foreign_ready", 32'(hi), 32'd0);
    @(posedge clk); #1; iomem_valid = 1'b0;

    // Reset in the middle of an acknowledged request while counting.
    wr(32'h0400_0004, 32'h0000_0100, 4'hF);
    wr(32'h0400_0008, 32'h0000_0080, 4'hF);
    wr(32'h0400_0000, 32'd1, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0400_000C; iomem_wstrb = 4'b0;
    @(posedge clk); #1;
    check("pre_rst_ready", {31'b0, iomem_ready}, 32'd1);
    check("pre_rst_pwm",   {31'b0, pwm_out}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("mid_rst_rdata", iomem_rdata, 32'd0);
    check("mid_rst_pwm",   {31'b0, pwm_out}, 32'd0);
    check("mid_rst_irq",   {31'b0, irq}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_rst_count",  32'h0400_000C, 32'd0);
    rd_chk("post_rst_ctrl",   32'h0400_0000, 32'd0);
    rd_chk("post_rst_period", 32'h0400_0004, 32'd0);

    repeat (3) @(posedge clk);
    checking = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
